// File: rtl/result_wb_dma.sv
// result_wb_dma: packs 16-bit engine results into 32-bit beats and issues memory write bursts (RESULT_WB_RELU_EN zeroes negative results)
module result_wb_dma #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_writes_en,
  input  logic              i_fifo_empty,
  input  logic [15:0]       i_fifo_dout,
  output logic              o_fifo_rd_en,
  input  logic              i_cmd_full,
  output logic              o_cmd_en,
  output logic [2:0]        o_cmd_instr,
  output logic [5:0]        o_cmd_bl,
  output logic [ADDR_W-1:0] o_cmd_byte_addr,
  input  logic              i_wr_full,
  output logic              o_wr_en,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_wr_mask,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_result_cnt
);
  localparam int BEATS = BURST_LEN / 2;
  localparam int BW = $clog2(BEATS + 1);
  localparam logic [BW-1:0] BEATS_V = BW'(BEATS);
  typedef enum logic [2:0] {IDLE, STREAM, CMD, FLUSH, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BW-1:0]     r_beats;
  logic              r_half;
  logic [15:0]       r_lo;
  logic              r_inflight;
  logic              r_hold_valid;
  logic [31:0]       r_hold_data;
  logic [15:0]       r_cnt;
  logic [15:0]       w_res;
  logic              w_cap_hi;
  logic              w_flush_wr;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_cmd_en;
`ifdef RESULT_WB_RELU_EN
  assign w_res = i_fifo_dout[15] ? 16'h0000 : i_fifo_dout;
`else
  assign w_res = i_fifo_dout;
`endif
  assign w_cap_hi   = r_inflight && r_half;
  assign w_flush_wr = (r_state == FLUSH) && r_half;
  assign w_pop      = (r_state == STREAM) && !i_fifo_empty && !r_hold_valid && !i_wr_full &&
                      !r_inflight && (r_beats < BEATS_V);
  assign w_wr_en    = !i_wr_full && (r_hold_valid || w_cap_hi || w_flush_wr);
  assign w_cmd_en   = (r_state == CMD) && !i_cmd_full;
  assign o_fifo_rd_en    = w_pop;
  assign o_wr_en         = w_wr_en;
  assign o_wr_data       = !w_wr_en ? 32'h0 : r_hold_valid ? r_hold_data :
                           w_flush_wr ? {16'h0000, r_lo} : {w_res, r_lo};
  assign o_wr_mask       = (w_wr_en && w_flush_wr) ? 4'b1100 : 4'b0000;
  assign o_cmd_en        = w_cmd_en;
  assign o_cmd_instr     = 3'b000;
  assign o_cmd_bl        = w_cmd_en ? 6'(r_beats - 1'b1) : 6'd0;
  assign o_cmd_byte_addr = w_cmd_en ? r_addr : '0;
  assign o_busy          = r_state != IDLE;
  assign o_done          = r_state == DONE;
  assign o_result_cnt    = r_cnt;
  // Burst FSM: capture/pack results, park stalled words, flush odd tail, issue command once beats are pushed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_beats      <= '0;
      r_half       <= 1'b0;
      r_lo         <= 16'h0;
      r_inflight   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 32'h0;
      r_cnt        <= 16'h0;
    end else begin
      r_inflight <= w_pop;
      case (r_state)
        IDLE: if (i_start) begin
          r_state      <= STREAM;
          r_addr       <= i_base_addr;
          r_cnt        <= 16'h0;
          r_beats      <= '0;
          r_half       <= 1'b0;
          r_hold_valid <= 1'b0;
        end
        STREAM: begin
          if (r_inflight) begin
            r_cnt <= r_cnt + 16'd1;
            if (!r_half) begin
              r_lo   <= w_res;
              r_half <= 1'b1;
            end else begin
              r_half  <= 1'b0;
              r_beats <= r_beats + 1'b1;
              if (i_wr_full) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= {w_res, r_lo};
              end
            end
          end else if (r_hold_valid && !i_wr_full) begin
            r_hold_valid <= 1'b0;
          end
          if (!r_inflight && !r_hold_valid) begin
            if (r_beats == BEATS_V) r_state <= CMD;
            else if (!i_writes_en && i_fifo_empty) r_state <= (r_beats != '0 || r_half) ? FLUSH : DONE;
          end
        end
        FLUSH: begin
          if (!r_half) r_state <= CMD;
          else if (!i_wr_full) begin
            r_half  <= 1'b0;
            r_beats <= r_beats + 1'b1;
          end
        end
        CMD: if (!i_cmd_full) begin
          r_addr  <= r_addr + ADDR_W'({r_beats, 2'b00});
          r_beats <= '0;
          r_state <= STREAM;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_wb_dma.sv
// tb_result_wb_dma: scoreboard bench for result_wb_dma (FIFO model, expected beats/commands queued at stimulus time)
module tb_result_wb_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [29:0] base_addr = '0;
  logic        writes_en = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        rd_en;
  logic        cmd_full = 1'b0;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic        wr_full = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        busy;
  logic        done;
  logic [15:0] result_cnt;

  result_wb_dma #(.BURST_LEN(16), .ADDR_W(30)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_writes_en(writes_en), .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout),
    .o_fifo_rd_en(rd_en), .i_cmd_full(cmd_full), .o_cmd_en(cmd_en),
    .o_cmd_instr(cmd_instr), .o_cmd_bl(cmd_bl), .o_cmd_byte_addr(cmd_addr),
    .i_wr_full(wr_full), .o_wr_en(wr_en), .o_wr_data(wr_data), .o_wr_mask(wr_mask),
    .o_busy(busy), .o_done(done), .o_result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  // Result FIFO model: read data valid the cycle after a pop
  logic [15:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (rd_en && !fifo_empty) begin
      fifo_dout <= mem[rp];
      rp <= rp + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_wd [$];
  logic [3:0]  exp_wm [$];
  logic [5:0]  exp_bl [$];
  logic [29:0] exp_ad [$];
  logic        m_have_lo;
  logic [15:0] m_lo;
  int          m_beats;
  logic [29:0] m_addr;
  int cyc = 0;
  int first_pop;
  int first_cmd;
  int beats_seen = 0;
  int total_beats;
  int cf_cnt;
  bit cf_fired;
  bit done_seen;
  bit have_wd;
  logic [31:0] first_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef RESULT_WB_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_start(input logic [29:0] b);
    m_addr = b;
    m_beats = 0;
    m_have_lo = 1'b0;
  endtask

  task automatic push_cmd();
    exp_bl.push_back(6'(m_beats - 1));
    exp_ad.push_back(m_addr);
    m_addr = m_addr + 30'(4 * m_beats);
    m_beats = 0;
  endtask

  task automatic push_res(input logic [15:0] v);
    mem[wp] = v;
    wp++;
    if (m_have_lo) begin
      exp_wd.push_back({relu(v), m_lo});
      exp_wm.push_back(4'b0000);
      m_have_lo = 1'b0;
      m_beats++;
      if (m_beats == 8) push_cmd();
    end else begin
      m_lo = relu(v);
      m_have_lo = 1'b1;
    end
  endtask

  task automatic model_end();
    if (m_have_lo) begin
      exp_wd.push_back({16'h0000, m_lo});
      exp_wm.push_back(4'b1100);
      m_have_lo = 1'b0;
      m_beats++;
    end
    if (m_beats > 0) push_cmd();
  endtask

  // One clock: observe outputs at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rd_en && first_pop < 0) first_pop = cyc;
    if (wr_en) begin
      if (!have_wd) begin
        first_wd = wr_data;
        have_wd = 1'b1;
      end
      beats_seen++;
      total_beats++;
      chk("wr_expected", exp_wd.size() != 0, 1);
      if (exp_wd.size() != 0) begin
        chk("wr_data", wr_data, exp_wd.pop_front());
        chk("wr_mask", wr_mask, exp_wm.pop_front());
      end
    end
    if (cmd_en) begin
      if (first_cmd < 0) first_cmd = cyc;
      chk("cmd_while_full", cmd_full, 0);
      chk("cmd_instr", cmd_instr, 3'b000);
      chk("cmd_expected", exp_bl.size() != 0, 1);
      if (exp_bl.size() != 0) begin
        chk("cmd_beats_pushed", beats_seen, int'(exp_bl[0]) + 1);
        chk("cmd_bl", cmd_bl, exp_bl.pop_front());
        chk("cmd_addr", cmd_addr, exp_ad.pop_front());
      end
      beats_seen = 0;
    end
    if (done) done_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then clock until done with optional wr_full window, cmd_full stall and a start while busy
  task automatic run(input int wf0, input int wf1, input bit cf_en, input int sb);
    int c;
    done_seen = 1'b0;
    have_wd = 1'b0;
    first_pop = -1;
    first_cmd = -1;
    total_beats = 0;
    cf_cnt = 0;
    cf_fired = 1'b0;
    c = 0;
    while (!done_seen && c < 300) begin
      wr_full = (c >= wf0) && (c < wf1);
      if (cf_en && !cf_fired && beats_seen == 8) begin
        cf_cnt = 3;
        cf_fired = 1'b1;
      end
      cmd_full = cf_cnt > 0;
      start = (c == 0) || (c == sb);
      if (c == sb) base_addr = 30'h0ABC0;
      tick();
      if (cf_cnt > 0) cf_cnt--;
      c++;
    end
    wr_full = 1'b0;
    cmd_full = 1'b0;
    start = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("done_pulse_low", done, 0);
    chk("idle_after_done", busy, 0);
    chk("wd_drained", exp_wd.size(), 0);
    chk("cmd_drained", exp_bl.size(), 0);
    chk("cmd_full_exercised", cf_fired, cf_en);
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_cmd", {cmd_en, cmd_instr, cmd_bl, cmd_addr}, 0);
    chk("rst_wr", {rd_en, wr_en, wr_data, wr_mask}, 0);
    chk("rst_status", {busy, done, result_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // full burst
    model_start(30'h100);
    for (int i = 1; i <= 16; i++) push_res(16'(i));
    model_end();
    base_addr = 30'h100;
    run(0, 0, 1'b0, -1);
    chk("full_first_word", first_wd, 32'h00020001);
    chk("full_beats", total_beats, 8);
    chk("full_cnt", result_cnt, 16);
    chk("full_cmd_latency", (first_cmd - first_pop) <= 34, 1);

    // odd tail
    model_start(30'h200);
    push_res(16'h1111);
    push_res(16'h2222);
    push_res(16'h3333);
    model_end();
    base_addr = 30'h200;
    run(0, 0, 1'b0, -1);
    chk("odd_first_word", first_wd, 32'h22221111);
    chk("odd_beats", total_beats, 2);
    chk("odd_cnt", result_cnt, 3);

    // back-to-back bursts with an ignored start while busy
    model_start(30'h0);
    for (int i = 0; i < 32; i++) push_res(16'(16'h0040 + 3 * i));
    model_end();
    base_addr = 30'h0;
    run(0, 0, 1'b0, 10);
    chk("b2b_beats", total_beats, 16);
    chk("b2b_cnt", result_cnt, 32);

    // backpressure at two phases of the pop cadence
    for (int p = 5; p <= 6; p++) begin
      model_start(30'h300);
      for (int i = 0; i < 16; i++) push_res(16'(16'h0A00 + i));
      model_end();
      base_addr = 30'h300;
      run(p, p + 5, 1'b1, -1);
      chk("bp_beats", total_beats, 8);
      chk("bp_cnt", result_cnt, 16);
    end

    // negative values (zeroed only when the clamp is built in)
    model_start(30'h400);
    push_res(16'hBC00);
    push_res(16'h3C00);
    model_end();
    base_addr = 30'h400;
    run(0, 0, 1'b0, -1);
`ifdef RESULT_WB_RELU_EN
    chk("relu_word", first_wd, 32'h3C000000);
`else
    chk("relu_word", first_wd, 32'h3C00BC00);
`endif
    chk("relu_cnt", result_cnt, 2);

    // nothing to write: straight to done
    model_start(30'h500);
    model_end();
    base_addr = 30'h500;
    run(0, 0, 1'b0, -1);
    chk("empty_beats", total_beats, 0);
    chk("empty_cnt", result_cnt, 0);

    // reset mid-burst, then restart from a new base
    model_start(30'h3000);
    for (int i = 1; i <= 5; i++) push_res(16'(i));
    base_addr = 30'h3000;
    writes_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && result_cnt != 5; c++) tick();
    chk("mid_cnt", result_cnt, 5);
    chk("mid_beats", beats_seen, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", {cmd_en, cmd_instr, cmd_bl, cmd_addr}, 0);
    chk("mid_rst_wr", {rd_en, wr_en, wr_data, wr_mask}, 0);
    chk("mid_rst_status", {busy, done, result_cnt}, 0);
    tick();
    rst_n = 1'b1;
    writes_en = 1'b0;
    beats_seen = 0;
    model_start(30'h4000);
    push_res(16'h0AAA);
    push_res(16'h0BBB);
    model_end();
    base_addr = 30'h4000;
    run(0, 0, 1'b0, -1);
    chk("restart_word", first_wd, 32'h0BBB0AAA);
    chk("restart_cnt", result_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
